shift_add_seq: RTL and testbench

- Parametrised control sequencer for the team's serial shift-add multiplier datapath. It generalises the fixed-length clear/load/add/shift controller to any operand width.
- Adds a start/busy/done handshake, a multiplier-bit-gated add, an abort input and an iteration count output.
- Sits between the top-level control logic and the multiplier datapath (operand registers, product register, adder).

---
 rtl/shift_add_seq.sv | 109 ++++++++++
 tb/tb_shift_add_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_seq.sv
// Control sequencer for a serial shift-add multiplier: clear, load, then WIDTH add/shift rounds, then a done pulse.
// Moore-decoded outputs except ldp (gated by b_lsb in ADD); 2*WIDTH+4 cycles per operation including the IDLE slot.
module shift_add_seq #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             b_lsb,
  output logic             clr,
  output logic             ld,
  output logic             ldp,
  output logic             shp,
  output logic             shb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_last;

  assign w_cnt_inc = r_count + CNT_W'(1);
  // >= rather than == so a corrupted count can never run past WIDTH rounds
  assign w_last    = (w_cnt_inc >= CNT_W'(WIDTH));
  assign count     = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Aborting out of SHIFT does not credit the interrupted iteration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_nxt == S_CLEAR) begin
      r_count <= '0;
    end else if (r_state == S_SHIFT && !abort) begin
      r_count <= w_cnt_inc;
    end
  end

  always_comb begin
    w_nxt = S_IDLE;
    clr   = 1'b0;
    ld    = 1'b0;
    ldp   = 1'b0;
    shp   = 1'b0;
    shb   = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nxt = (start && !abort) ? S_CLEAR : S_IDLE;
      end
      S_CLEAR: begin
        clr   = 1'b1;
        busy  = 1'b1;
        w_nxt = S_LOAD;
      end
      S_LOAD: begin
        ld    = 1'b1;
        busy  = 1'b1;
        w_nxt = S_ADD;
      end
      S_ADD: begin
        ldp   = b_lsb;
        busy  = 1'b1;
        w_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        shp   = 1'b1;
        shb   = 1'b1;
        busy  = 1'b1;
        w_nxt = w_last ? S_DONE : S_ADD;
      end
      S_DONE: begin
        done  = 1'b1;
        busy  = 1'b1;
        w_nxt = S_IDLE;
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
    if (abort) begin
      w_nxt = S_IDLE;
    end
  end

endmodule

// File: tb/tb_shift_add_seq.sv
// Bench for shift_add_seq at WIDTH=4 (with a shift-add datapath model) and WIDTH=8.
// Expected done pulses are queued at issue time and matched by per-DUT monitors.
module tb_shift_add_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=4 instance
  logic       start4 = 1'b0, abort4 = 1'b0, blsb_drv4 = 1'b0, use_dp = 1'b0;
  logic       blsb4;
  logic       clr4, ld4, ldp4, shp4, shb4, busy4, done4;
  logic [2:0] count4;
  logic [6:0] vec4;

  // WIDTH=8 instance
  logic       start8 = 1'b0, abort8 = 1'b0, blsb8 = 1'b0;
  logic       clr8, ld8, ldp8, shp8, shb8, busy8, done8;
  logic [3:0] count8;
  logic [6:0] vec8;

  // Datapath model driven by the WIDTH=4 controls
  logic [3:0] dp_ain = 4'd0, dp_bin = 4'd0, dp_a = 4'd0, dp_b = 4'd0;
  logic [8:0] dp_acc = 9'd0;

  assign blsb4 = use_dp ? dp_b[0] : blsb_drv4;
  assign vec4  = {clr4, ld4, ldp4, shp4, shb4, busy4, done4};
  assign vec8  = {clr8, ld8, ldp8, shp8, shb8, busy8, done8};

  shift_add_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(rst), .start(start4), .abort(abort4), .b_lsb(blsb4),
    .clr(clr4), .ld(ld4), .ldp(ldp4), .shp(shp4), .shb(shb4),
    .busy(busy4), .done(done4), .count(count4)
  );

  shift_add_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(rst), .start(start8), .abort(abort8), .b_lsb(blsb8),
    .clr(clr8), .ld(ld8), .ldp(ldp8), .shp(shp8), .shb(shb8),
    .busy(busy8), .done(done8), .count(count8)
  );

  always @(posedge clk) begin
    if (clr4) dp_acc <= 9'd0;
    if (ld4) begin
      dp_a <= dp_ain;
      dp_b <= dp_bin;
    end
    if (ldp4) dp_acc[8:4] <= {1'b0, dp_acc[7:4]} + {1'b0, dp_a};
    if (shp4) dp_acc <= dp_acc >> 1;
    if (shb4) dp_b <= dp_b >> 1;
  end

  typedef struct {
    int cyc;
    int cnt;
    int prod;
    bit chk_prod;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d (cyc=%0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL d4_unexpected_done actual=1 expected=0 (cyc=%0d)", cyc);
      end else begin
        e = q4.pop_front();
        chk("d4_done_cyc", cyc, e.cyc);
        chk("d4_done_count", 32'(count4), e.cnt);
        if (e.chk_prod) chk("d4_product", 32'(dp_acc[7:0]), e.prod);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL d8_unexpected_done actual=1 expected=0 (cyc=%0d)", cyc);
      end else begin
        e = q8.pop_front();
        chk("d8_done_cyc", cyc, e.cyc);
        chk("d8_done_count", 32'(count8), e.cnt);
      end
    end
  end

  // Per-cycle {clr,ld,ldp,shp,shb,busy,done} for 11*13 (b_lsb 1,0,1,1), cycles 1..12 after start
  logic [6:0] pat_tbl [12] = '{7'h42, 7'h22, 7'h12, 7'h0E, 7'h02, 7'h0E,
                               7'h12, 7'h0E, 7'h12, 7'h0E, 7'h03, 7'h00};

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int n_ldp;
    int n_sh;

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_vec4", 32'(vec4), 0);
    chk("rst_count4", 32'(count4), 0);
    chk("rst_vec8", 32'(vec8), 0);
    chk("rst_count8", 32'(count8), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_hold_vec4", 32'(vec4), 0);
    end

    // 11 * 13 through the datapath model, cycle-exact decode
    use_dp = 1'b1;
    dp_ain = 4'd11;
    dp_bin = 4'd13;
    c = cyc;
    q4.push_back('{c + 11, 4, 143, 1'b1});
    start4 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) start4 = 1'b0;
      chk($sformatf("pat_cycle%0d", k + 1), 32'(vec4), 32'(pat_tbl[k]));
    end
    repeat (3) @(negedge clk);
    chk("count_held_idle", 32'(count4), 4);
    use_dp = 1'b0;

    // WIDTH=8, b_lsb held low
    c = cyc;
    q8.push_back('{c + 19, 8, 0, 1'b0});
    start8 = 1'b1;
    n_ldp = 0;
    n_sh = 0;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      if (k == 0) start8 = 1'b0;
      if (ldp8) n_ldp++;
      if (shp8 && shb8) n_sh++;
    end
    chk("d8_ldp_cycles", n_ldp, 0);
    chk("d8_shift_cycles", n_sh, 8);
    chk("d8_idle_after", 32'(busy8), 0);

    // Abort in the second SHIFT
    blsb_drv4 = 1'b1;
    c = cyc;
    start4 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) start4 = 1'b0;
    end
    chk("abort_in_shift", 32'(vec4), 32'(7'h0E));
    chk("abort_pre_count", 32'(count4), 1);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    chk("abort_busy", 32'(busy4), 0);
    chk("abort_count", 32'(count4), 1);
    repeat (4) @(negedge clk);
    chk("abort_count_held", 32'(count4), 1);
    c = cyc;
    q4.push_back('{c + 11, 4, 0, 1'b0});
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (13) @(negedge clk);

    // Start held high: back-to-back every 12 cycles
    blsb_drv4 = 1'b0;
    c = cyc;
    q4.push_back('{c + 11, 4, 0, 1'b0});
    q4.push_back('{c + 23, 4, 0, 1'b0});
    q4.push_back('{c + 35, 4, 0, 1'b0});
    start4 = 1'b1;
    repeat (36) @(negedge clk);
    start4 = 1'b0;
    chk("b2b_idle_slot", 32'(busy4), 0);
    repeat (3) @(negedge clk);
    chk("b2b_stopped", 32'(busy4), 0);

    // Start pulses while busy are ignored
    c = cyc;
    q4.push_back('{c + 11, 4, 0, 1'b0});
    start4 = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start4 = (k == 3 || k == 6 || k == 10) ? 1'b1 : 1'b0;
    end
    chk("busy_start_ignored", 32'(busy4), 0);

    // start and abort together in IDLE
    start4 = 1'b1;
    abort4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    abort4 = 1'b0;
    chk("start_abort_idle", 32'(vec4), 0);
    chk("start_abort_count", 32'(count4), 4);

    // Asynchronous reset during the third ADD
    blsb_drv4 = 1'b1;
    start4 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) start4 = 1'b0;
    end
    chk("pre_reset_add", 32'(vec4), 32'(7'h12));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vec4", 32'(vec4), 0);
    chk("async_rst_count4", 32'(count4), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_reset_idle", 32'(vec4), 0);

    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
